// File: rtl/jt10_adpcma_feed_if.sv
// ROM fetch handshake between the ADPCM-A nibble feeder (master) and sample ROM (slave).
// rom_cs is held with a stable rom_addr until rom_ok; rom_data is valid alongside rom_ok.
interface jt10_adpcma_feed_if #(
    parameter int AW = 24
);
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;

    modport master (output rom_addr, output rom_cs, input rom_data, input rom_ok);
    modport slave  (input rom_addr, input rom_cs, output rom_data, output rom_ok);
endinterface

// File: rtl/jt10_adpcma_feed.sv
// ADPCM-A nibble feeder: one-byte buffer per channel refilled from ROM, nibbles out high-first per slot.
// Slot outputs are registered on cen; a starved slot emits chon=0 and sets underrun instead of stalling.
module jt10_adpcma_feed #(
    parameter int AW = 24,
    parameter int CH = 6
) (
    input  logic               rst_n,
    input  logic               clk,
    input  logic               cen,
    input  logic [2:0]         wr_ch,
    input  logic               wr_start,
    input  logic               wr_end,
    input  logic [15:0]        din,
    input  logic [CH-1:0]      kon,
    input  logic [CH-1:0]      kof,
    jt10_adpcma_feed_if.master rom,
    output logic [2:0]         slot,
    output logic [3:0]         data,
    output logic               chon,
    output logic               clr,
    output logic [CH-1:0]      flag,
    output logic [CH-1:0]      underrun
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam int         HW      = AW - 8;

    logic [HW-1:0] start_r [CH];
    logic [HW-1:0] end_r   [CH];
    logic [AW-1:0] addr    [CH];
    logic [7:0]    bdat    [CH];
    logic [CH-1:0] on;
    logic [CH-1:0] bvalid;
    logic [CH-1:0] phase;
    logic [CH-1:0] pend_clr;
    logic [0:0]    st;
    logic [2:0]    cur;
    logic [2:0]    last;
    logic          stale;

    logic [CH-1:0] want;
    logic          pick_vld;
    logic [2:0]    pick;
    logic [2:0]    idx;
    logic [2:0]    ns;

    assign want = on & ~bvalid;
    assign ns   = (slot == 3'(CH - 1)) ? 3'd0 : slot + 3'd1;

    // Scan from the channel after the last one served; the nearest candidate is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int i = CH; i >= 1; i--) begin
            idx = 3'((int'(last) + i) % CH);
            if (want[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                start_r[i] <= '0;
                end_r[i]   <= '0;
                addr[i]    <= '0;
                bdat[i]    <= '0;
            end
            on           <= '0;
            bvalid       <= '0;
            phase        <= '0;
            pend_clr     <= '0;
            st           <= ST_IDLE;
            cur          <= '0;
            last         <= 3'(CH - 1);
            stale        <= 1'b0;
            rom.rom_addr <= '0;
            rom.rom_cs   <= 1'b0;
            slot         <= '0;
            data         <= '0;
            chon         <= 1'b0;
            clr          <= 1'b0;
            flag         <= '0;
            underrun     <= '0;
        end else begin
            if (wr_start && ({1'b0, wr_ch} < 4'(CH))) start_r[wr_ch] <= din[HW-1:0];
            if (wr_end   && ({1'b0, wr_ch} < 4'(CH))) end_r[wr_ch]   <= din[HW-1:0];

            if (st == ST_IDLE) begin
                if (pick_vld) begin
                    rom.rom_addr <= addr[pick];
                    rom.rom_cs   <= 1'b1;
                    cur          <= pick;
                    last         <= pick;
                    stale        <= kon[pick] | kof[pick];
                    st           <= ST_WAIT;
                end
            end else begin
                // A key event while in flight means the byte belongs to a stale address.
                if (kon[cur] | kof[cur]) stale <= 1'b1;
                if (rom.rom_ok) begin
                    if (!stale && !kon[cur] && !kof[cur]) begin
                        bdat[cur]   <= rom.rom_data;
                        bvalid[cur] <= 1'b1;
                    end
                    rom.rom_cs <= 1'b0;
                    st         <= ST_IDLE;
                end
            end

            if (cen) begin
                slot <= ns;
                chon <= 1'b0;
                data <= '0;
                clr  <= 1'b0;
                if (pend_clr[ns]) begin
                    clr          <= 1'b1;
                    pend_clr[ns] <= 1'b0;
                end else if (on[ns] && bvalid[ns]) begin
                    chon      <= 1'b1;
                    data      <= phase[ns] ? bdat[ns][3:0] : bdat[ns][7:4];
                    phase[ns] <= ~phase[ns];
                    if (phase[ns]) begin
                        bvalid[ns] <= 1'b0;
                        if (addr[ns][7:0] == 8'hFF && addr[ns][AW-1:8] == end_r[ns]) begin
                            on[ns]   <= 1'b0;
                            flag[ns] <= 1'b1;
                        end else begin
                            addr[ns] <= addr[ns] + AW'(1);
                        end
                    end
                end else if (on[ns]) begin
                    underrun[ns] <= 1'b1;
                end
            end

            // Key events come last so they override any slot or fetch update of the same cycle.
            for (int i = 0; i < CH; i++) begin
                if (kon[i]) begin
                    addr[i]     <= {start_r[i], 8'h00};
                    bvalid[i]   <= 1'b0;
                    phase[i]    <= 1'b0;
                    on[i]       <= 1'b1;
                    pend_clr[i] <= 1'b1;
                    flag[i]     <= 1'b0;
                    underrun[i] <= 1'b0;
                end else if (kof[i]) begin
                    on[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt10_adpcma_feed.sv
// Directed and randomized bench for jt10_adpcma_feed: ROM responder, scoreboard of expected nibble streams.
`timescale 1ns/1ps
module tb_jt10_adpcma_feed;
    localparam int AW = 24;
    localparam int CH = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cen = 1'b0;
    logic [2:0]    wr_ch = '0;
    logic          wr_start = 1'b0;
    logic          wr_end = 1'b0;
    logic [15:0]   din = '0;
    logic [CH-1:0] kon = '0;
    logic [CH-1:0] kof = '0;
    logic [2:0]    slot;
    logic [3:0]    data;
    logic          chon;
    logic          clr;
    logic [CH-1:0] flag;
    logic [CH-1:0] underrun;

    jt10_adpcma_feed_if #(.AW(AW)) rom ();

    jt10_adpcma_feed #(.AW(AW), .CH(CH)) dut (
        .rst_n(rst_n), .clk(clk), .cen(cen), .wr_ch(wr_ch), .wr_start(wr_start),
        .wr_end(wr_end), .din(din), .kon(kon), .kof(kof), .rom(rom), .slot(slot),
        .data(data), .chon(chon), .clr(clr), .flag(flag), .underrun(underrun)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: each keyed channel is an expected nibble stream over its byte range.
    bit          act [CH];
    bit          pclr [CH];
    bit          fin [CH];
    bit          starved [CH];
    int          pos [CH];
    int          total [CH];
    logic [23:0] base [CH];
    logic [15:0] st_reg [CH];
    logic [15:0] en_reg [CH];
    int          exp_slot = 0;
    bit          mon_en = 1'b0;
    logic [5:0]  ch0_log [$];

    int          rom_lat = 2;
    int          cen_mode = 0;
    bit          hold_cen = 1'b0;
    int          req_cnt = 0;
    logic [23:0] req_q [$];

    function automatic logic [7:0] rom_byte(logic [23:0] a);
        if (a == 24'h001000) return 8'hA5;
        if (a == 24'h001001) return 8'h3C;
        return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            act[i] = 0; pclr[i] = 0; fin[i] = 0; starved[i] = 0; pos[i] = 0;
            st_reg[i] = '0; en_reg[i] = '0;
        end
        exp_slot = 0;
    endtask

    task automatic check_slot();
        int          s;
        logic [7:0]  b;
        logic [3:0]  nib;
        logic [CH-1:0] fv, uv;
        exp_slot = (exp_slot == CH - 1) ? 0 : exp_slot + 1;
        s = exp_slot;
        chk("slot", 32'(slot), 32'(s));
        if (s == 0 && (clr || chon)) ch0_log.push_back({clr, chon, data});
        if (pclr[s]) begin
            chk("clr_slot", 32'({clr, chon}), 32'(2'b10));
            pclr[s] = 0;
        end else begin
            chk("clr_idle", 32'(clr), 32'(0));
            if (!act[s]) begin
                chk("chon_off", 32'({chon, data}), 32'(0));
            end else if (chon) begin
                b   = rom_byte(base[s] + 24'(pos[s] / 2));
                nib = pos[s][0] ? b[3:0] : b[7:4];
                chk("nibble", 32'(data), 32'(nib));
                pos[s]++;
                if (pos[s] == total[s]) begin act[s] = 0; fin[s] = 1; end
            end else begin
                chk("data_starved", 32'(data), 32'(0));
                starved[s] = 1;
            end
        end
        for (int i = 0; i < CH; i++) begin fv[i] = fin[i]; uv[i] = starved[i]; end
        chk("flag", 32'(flag), 32'(fv));
        chk("underrun", 32'(underrun), 32'(uv));
    endtask

    always @(posedge clk) begin : monitor
        bit c;
        c = cen && rst_n;
        #1;
        if (c && mon_en) check_slot();
    end

    initial begin : cen_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk); #1;
            if (hold_cen || cen_mode == 0) cen = 1'b0;
            else if (cen_mode < 0) cen = ($urandom_range(0, 2) == 0);
            else begin
                cnt++;
                if (cnt >= cen_mode) begin cnt = 0; cen = 1'b1; end
                else cen = 1'b0;
            end
        end
    end

    initial begin : rom_resp
        logic [23:0] a;
        int          lat;
        bit          alive;
        bit          prev_ok;
        rom.rom_ok = 1'b0;
        rom.rom_data = '0;
        forever begin
            @(posedge clk); #1;
            prev_ok = rom.rom_ok;
            rom.rom_ok = 1'b0;
            if (prev_ok && rst_n) chk("rom_cs_drop", 32'(rom.rom_cs), 32'(0));
            else if (rom.rom_cs && rst_n) begin
                a = rom.rom_addr;
                req_cnt++;
                req_q.push_back(a);
                lat = (rom_lat < 0) ? $urandom_range(1, 5) : rom_lat;
                alive = 1;
                for (int k = 1; k < lat && alive; k++) begin
                    @(posedge clk); #1;
                    if (!rom.rom_cs) alive = 0;
                    else chk("rom_hold", 32'(rom.rom_addr), 32'(a));
                end
                if (alive) begin rom.rom_data = rom_byte(a); rom.rom_ok = 1'b1; end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int ch, logic [15:0] s, logic [15:0] e);
        @(negedge clk); wr_ch = 3'(ch); din = s; wr_start = 1'b1;
        @(negedge clk); wr_start = 1'b0; din = e; wr_end = 1'b1;
        @(negedge clk); wr_end = 1'b0;
        if (ch < CH) begin st_reg[ch] = s; en_reg[ch] = e; end
    endtask

    task automatic key(logic [CH-1:0] on_m, logic [CH-1:0] off_m);
        @(negedge clk);
        hold_cen = 1'b1; kon = on_m; kof = off_m;
        for (int i = 0; i < CH; i++) begin
            if (on_m[i]) begin
                act[i] = 1; pclr[i] = 1; fin[i] = 0; starved[i] = 0; pos[i] = 0;
                base[i]  = {st_reg[i], 8'h00};
                total[i] = (int'({en_reg[i], 8'hFF}) - int'(base[i]) + 1) * 2;
            end else if (off_m[i]) act[i] = 0;
        end
        @(negedge clk); kon = '0; kof = '0; hold_cen = 1'b0;
    endtask

    task automatic wait_cs(int budget);
        int k;
        k = 0;
        while (!rom.rom_cs && k < budget) begin @(negedge clk); k++; end
        chk("wait_rom_cs", 32'(rom.rom_cs), 32'(1));
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_rom_cs", 32'(rom.rom_cs), 32'(0));
        chk("rst_outputs", 32'({slot, data, chon, clr, flag, underrun}), 32'(0));
        model_clear();
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin : main
        int k;
        int r;
        logic [5:0] t1_exp [5];
        t1_exp = '{6'h20, 6'h1A, 6'h15, 6'h13, 6'h1C};
        model_clear();
        #1 rst_n = 1'b0;
        #1;
        chk("reset_rom_cs", 32'(rom.rom_cs), 32'(0));
        chk("reset_outputs", 32'({slot, data, chon, clr, flag, underrun}), 32'(0));
        tick(3);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic playback with the known bytes A5, 3C.
        wr(0, 16'h0010, 16'h0010);
        rom_lat = 2; cen_mode = 2;
        ch0_log.delete();
        key(6'b000001, 6'b0);
        tick(120);
        chk("t1_log_len", 32'(ch0_log.size() >= 5), 32'(1));
        if (ch0_log.size() >= 5)
            for (int i = 0; i < 5; i++) chk("t1_seq", 32'(ch0_log[i]), 32'(t1_exp[i]));
        key(6'b0, 6'b000001);

        // Play through to the end address.
        wr(0, 16'h0020, 16'h0020);
        cen_mode = 1;
        key(6'b000001, 6'b0);
        k = 0;
        while (!flag[0] && k < 5000) begin @(negedge clk); k++; end
        chk("t2_flag", 32'(flag[0]), 32'(1));
        chk("t2_nibbles", 32'(pos[0]), 32'(512));
        r = req_cnt;
        tick(200);
        chk("t2_no_fetch", 32'(req_cnt), 32'(r));

        // Slow ROM starves the channel.
        wr(0, 16'h0030, 16'h0031);
        rom_lat = 40;
        key(6'b000001, 6'b0);
        tick(600);
        chk("t3_underrun", 32'(underrun[0]), 32'(1));
        chk("t3_progress", 32'(pos[0] > 4), 32'(1));
        rom_lat = 2;
        key(6'b0, 6'b000001);
        tick(50);

        // Round-robin fetch order after reset.
        do_reset();
        for (int i = 1; i < CH; i++) wr(i, 16'(16'h0040 + i), 16'(16'h0040 + i));
        rom_lat = 1; cen_mode = 4;
        req_q.delete();
        key(6'b111110, 6'b0);
        tick(400);
        chk("t4_nreq", 32'(req_q.size() >= 5), 32'(1));
        if (req_q.size() >= 5)
            for (int i = 0; i < 5; i++) chk("t4_rr_order", 32'(req_q[i][23:8]), 32'(16'h0041 + i));
        chk("t4_no_underrun", 32'(underrun), 32'(0));

        // Key events during an in-flight fetch.
        key(6'b0, 6'b111110);
        tick(30);
        rom_lat = 20; cen_mode = 2;
        wr(2, 16'h0050, 16'h0050);
        key(6'b000100, 6'b0);
        wait_cs(50);
        chk("t5_addr", 32'(rom.rom_addr), 32'(24'h005000));
        key(6'b0, 6'b000100);
        r = req_cnt;
        tick(100);
        chk("t5_no_refetch", 32'(req_cnt), 32'(r));
        key(6'b000100, 6'b0);
        wait_cs(50);
        wr(2, 16'h0070, 16'h0070);
        key(6'b000100, 6'b0);
        rom_lat = 2;
        tick(300);
        chk("t5_ch2_restart", 32'(pos[2] > 0), 32'(1));
        wr(3, 16'h0060, 16'h0060);
        key(6'b001000, 6'b001000);
        tick(200);
        chk("t5_ch3_plays", 32'(pos[3] > 0), 32'(1));

        // Reset while a fetch is waiting.
        key(6'b0, 6'b111111);
        tick(20);
        rom_lat = 30;
        key(6'b000001, 6'b0);
        wait_cs(50);
        tick(3);
        do_reset();
        cen_mode = 1;
        tick(100);
        chk("t6_off_flag", 32'(flag), 32'(0));
        chk("t6_off_underrun", 32'(underrun), 32'(0));
        chk("t6_no_fetch", 32'(rom.rom_cs), 32'(0));

        // Randomized keying, latencies and cen pattern.
        rom_lat = -1; cen_mode = -1;
        for (int it = 0; it < 40; it++) begin
            int c;
            logic [15:0] s;
            c = $urandom_range(0, CH - 1);
            s = 16'($urandom_range(0, 16'hFF00));
            key(6'b0, 6'(1 << c));
            wr(c, s, s + 16'($urandom_range(0, 1)));
            key((6'($urandom) & 6'($urandom)) | 6'(1 << c), 6'($urandom) & 6'($urandom) & 6'($urandom));
            tick($urandom_range(20, 120));
        end

        cen_mode = 0;
        tick(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
